// File: rtl/sd_sector_arbiter_pkg.sv
// Shared types and sizes for the SD sector arbiter (sd_sector_arbiter).
package sd_arb_pkg;
   localparam int SD_NDRV  = 3;
   localparam int SD_LBA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } sd_arb_state_t;
endpackage

// File: rtl/sd_sector_arbiter_if.sv
// HPS block-transfer bus between the sector arbiter (master) and hps_io (slave).
interface sd_sector_arbiter_if
   import sd_arb_pkg::*;
#(
   parameter int NDRV  = SD_NDRV,
   parameter int LBA_W = SD_LBA_W
);
   logic [LBA_W-1:0] sd_lba;
   logic [NDRV-1:0]  sd_rd;
   logic [NDRV-1:0]  sd_wr;
   logic             sd_ack;

   modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
   modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/sd_sector_arbiter_rr.sv
// Combinational round-robin picker: nearest pending slot after the last grant wins.
module sd_arb_rr
   import sd_arb_pkg::*;
#(
   parameter int NDRV = SD_NDRV
) (
   input  logic [NDRV-1:0] pend,
   input  logic [1:0]      last,
   output logic            grant_valid,
   output logic [1:0]      grant_idx
);
   logic [2:0] raw_s;
   logic [1:0] idx_s;

   // Scan farthest-first so the closest hit after last overrides earlier ones.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 2'd0;
      raw_s       = 3'd0;
      idx_s       = 2'd0;
      for (int k = NDRV; k >= 1; k--) begin
         raw_s       = {1'b0, last} + 3'(k);
         idx_s       = (raw_s >= 3'(NDRV)) ? 2'(raw_s - 3'(NDRV)) : raw_s[1:0];
         grant_valid = grant_valid | pend[idx_s];
         grant_idx   = pend[idx_s] ? idx_s : grant_idx;
      end
   end
endmodule

// File: rtl/sd_sector_arbiter.sv
// Schedules per-drive sector requests onto the single hps_io block bus.
// Optional SD_WRITE_EN: when undefined, write requests are rejected with err.
module sd_sector_arbiter
   import sd_arb_pkg::*;
#(
   parameter int          NDRV    = SD_NDRV,
   parameter int          LBA_W   = SD_LBA_W,
   parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
   input  logic                  clk_sys,
   input  logic                  areset,
   input  logic [NDRV-1:0]       req_valid,
   input  logic [NDRV-1:0]       req_wr,
   input  logic [NDRV*LBA_W-1:0] req_lba,
   output logic [NDRV-1:0]       req_ready,
   output logic [NDRV-1:0]       done,
   output logic [NDRV-1:0]       err,
   input  logic [NDRV-1:0]       img_mounted,
   sd_sector_arbiter_if.master   sd,
   output logic                  busy,
   output logic [1:0]            active_drv
);
   sd_arb_state_t    state_r, state_nxt_s;
   logic [NDRV-1:0]  pend_r, done_r, err_r;
   logic [LBA_W-1:0] lba_r [NDRV];
   logic [1:0]       last_r, last_nxt_s, act_r, act_nxt_s, grant_idx_s;
   logic             act_err_r, act_err_nxt_s, grant_valid_s, timeout_s;
   logic [23:0]      cnt_r, cnt_nxt_s;
   logic [LBA_W-1:0] sd_lba_r, sd_lba_nxt_s;
   logic [NDRV-1:0]  sd_rd_r, sd_rd_nxt_s, sd_wr_r, sd_wr_nxt_s;
   logic [NDRV-1:0]  accept_s, eligible_s, mount_abort_s, wr_reject_s;
   logic [NDRV-1:0]  fsm_done_s, fsm_err_s;
`ifdef SD_WRITE_EN
   logic [NDRV-1:0]  wr_r;
   assign wr_reject_s = '0;
`else
   assign wr_reject_s = accept_s & req_wr;
`endif

   assign accept_s   = req_valid & ~pend_r;
   // A slot whose completion is being reported, or which is being unmounted, must not be granted.
   assign eligible_s = pend_r & ~done_r & ~img_mounted;
   assign timeout_s  = (cnt_r == (TIMEOUT - 24'd1));

   assign req_ready  = ~pend_r;
   assign done       = done_r;
   assign err        = err_r;
   assign busy       = (state_r != IDLE);
   assign active_drv = act_r;
   assign sd.sd_lba  = sd_lba_r;
   assign sd.sd_rd   = sd_rd_r;
   assign sd.sd_wr   = sd_wr_r;

   sd_arb_rr #(.NDRV(NDRV)) u_rr (
      .pend        (eligible_s),
      .last        (last_r),
      .grant_valid (grant_valid_s),
      .grant_idx   (grant_idx_s)
   );

   // Unmount of a waiting, non-granted slot aborts it immediately.
   always_comb begin
      mount_abort_s = '0;
      for (int i = 0; i < NDRV; i++) begin
         mount_abort_s[i] = img_mounted[i] & pend_r[i] & ~done_r[i] & ~(busy & (act_r == 2'(i)));
      end
   end

   // State register.
   always_ff @(posedge clk_sys) begin
      if (areset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decision.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    state_nxt_s = grant_valid_s ? ISSUE : IDLE;
         ISSUE:   state_nxt_s = sd.sd_ack ? XFER : (timeout_s ? DONE : ISSUE);
         XFER:    state_nxt_s = sd.sd_ack ? XFER : DONE;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Per-state outputs and datapath updates.
   always_comb begin
      sd_lba_nxt_s  = sd_lba_r;
      sd_rd_nxt_s   = sd_rd_r;
      sd_wr_nxt_s   = sd_wr_r;
      act_nxt_s     = act_r;
      cnt_nxt_s     = cnt_r;
      last_nxt_s    = last_r;
      act_err_nxt_s = act_err_r | (busy & img_mounted[act_r]);
      fsm_done_s    = '0;
      fsm_err_s     = '0;
      case (state_r)
         IDLE: begin
            act_err_nxt_s = 1'b0;
            if (grant_valid_s) begin
               act_nxt_s    = grant_idx_s;
               sd_lba_nxt_s = lba_r[grant_idx_s];
               cnt_nxt_s    = 24'd0;
               sd_rd_nxt_s  = '0;
               sd_wr_nxt_s  = '0;
`ifdef SD_WRITE_EN
               if (wr_r[grant_idx_s]) begin
                  sd_wr_nxt_s[grant_idx_s] = 1'b1;
               end else begin
                  sd_rd_nxt_s[grant_idx_s] = 1'b1;
               end
`else
               sd_rd_nxt_s[grant_idx_s] = 1'b1;
`endif
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ISSUE: begin
            if (sd.sd_ack) begin
               sd_rd_nxt_s = '0;
               sd_wr_nxt_s = '0;
            end else if (timeout_s) begin
               sd_rd_nxt_s   = '0;
               sd_wr_nxt_s   = '0;
               act_err_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + 24'd1;
            end
         end
         XFER: begin
            cnt_nxt_s = cnt_r;
         end
         DONE: begin
            fsm_done_s[act_r] = 1'b1;
            fsm_err_s[act_r]  = act_err_r | img_mounted[act_r];
            last_nxt_s        = act_r;
         end
         default: begin
            sd_rd_nxt_s = '0;
            sd_wr_nxt_s = '0;
         end
      endcase
   end

   // Datapath and completion registers.
   always_ff @(posedge clk_sys) begin
      if (areset) begin
         sd_lba_r  <= '0;
         sd_rd_r   <= '0;
         sd_wr_r   <= '0;
         act_r     <= 2'd0;
         cnt_r     <= 24'd0;
         last_r    <= 2'd0;
         act_err_r <= 1'b0;
         done_r    <= '0;
         err_r     <= '0;
      end else begin
         sd_lba_r  <= sd_lba_nxt_s;
         sd_rd_r   <= sd_rd_nxt_s;
         sd_wr_r   <= sd_wr_nxt_s;
         act_r     <= act_nxt_s;
         cnt_r     <= cnt_nxt_s;
         last_r    <= last_nxt_s;
         act_err_r <= act_err_nxt_s;
         done_r    <= fsm_done_s | mount_abort_s | wr_reject_s;
         err_r     <= fsm_err_s | mount_abort_s | wr_reject_s;
      end
   end

   // Request slots: freed the cycle after their completion pulse.
   always_ff @(posedge clk_sys) begin
      if (areset) begin
         pend_r <= '0;
         lba_r  <= '{default: '0};
`ifdef SD_WRITE_EN
         wr_r   <= '0;
`endif
      end else begin
         for (int i = 0; i < NDRV; i++) begin
            if (accept_s[i]) begin
               pend_r[i] <= 1'b1;
               lba_r[i]  <= req_lba[i*LBA_W +: LBA_W];
`ifdef SD_WRITE_EN
               wr_r[i]   <= req_wr[i];
`endif
            end else if (done_r[i]) begin
               pend_r[i] <= 1'b0;
            end else begin
               pend_r[i] <= pend_r[i];
            end
         end
      end
   end
endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed and randomized bench for sd_sector_arbiter against a transaction-level round-robin model.
module tb_sd_sector_arbiter;
   import sd_arb_pkg::*;

   localparam int          NDRV  = SD_NDRV;
   localparam int          LBA_W = SD_LBA_W;
   localparam logic [23:0] TMO   = 24'd16;

   logic                  clk_sys = 1'b0;
   logic                  areset;
   logic [NDRV-1:0]       req_valid, req_wr, req_ready, done, err, img_mounted;
   logic [NDRV*LBA_W-1:0] req_lba;
   logic                  busy;
   logic [1:0]            active_drv;

   sd_sector_arbiter_if #(.NDRV(NDRV), .LBA_W(LBA_W)) sd_bus ();

   sd_sector_arbiter #(.NDRV(NDRV), .LBA_W(LBA_W), .TIMEOUT(TMO)) dut (
      .clk_sys     (clk_sys),
      .areset      (areset),
      .req_valid   (req_valid),
      .req_wr      (req_wr),
      .req_lba     (req_lba),
      .req_ready   (req_ready),
      .done        (done),
      .err         (err),
      .img_mounted (img_mounted),
      .sd          (sd_bus),
      .busy        (busy),
      .active_drv  (active_drv)
   );

   always #5 clk_sys = ~clk_sys;

   int               n_total = 0;
   int               n_pass  = 0;
   bit               m_pend [NDRV];
   bit               m_wr   [NDRV];
   logic [LBA_W-1:0] m_lba  [NDRV];
   int               m_last;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [NDRV-1:0] onehot(input int e);
      logic [NDRV-1:0] v;
      v = '0;
      if (e >= 0 && e < NDRV) v[e] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < NDRV; d++) begin
         m_pend[d] = 1'b0;
         m_wr[d]   = 1'b0;
         m_lba[d]  = '0;
      end
      m_last = 0;
   endtask

   function automatic int next_grant();
      for (int k = 1; k <= NDRV; k++) begin
         int d;
         d = (m_last + k) % NDRV;
         if (m_pend[d]) return d;
      end
      return -1;
   endfunction

   // Strobe a set of drives with random LBAs; the model records only slots that were empty.
   task automatic strobe(input logic [NDRV-1:0] mask, input logic [NDRV-1:0] wr);
      logic [LBA_W-1:0] v;
      for (int d = 0; d < NDRV; d++) begin
         if (mask[d]) begin
            v = LBA_W'($urandom);
            req_lba[d*LBA_W +: LBA_W] = v;
`ifdef SD_WRITE_EN
            if (!m_pend[d]) begin
`else
            if (!m_pend[d] && !wr[d]) begin
`endif
               m_pend[d] = 1'b1;
               m_wr[d]   = wr[d];
               m_lba[d]  = v;
            end
         end
      end
      req_valid = mask;
      req_wr    = wr;
      tick();
      req_valid = '0;
      req_wr    = '0;
   endtask

   task automatic expect_grant(input string tag, output int e);
      logic [NDRV-1:0] oh;
      int ei;
      e = next_grant();
      ei = (e < 0) ? 0 : e;
      for (int i = 0; i < 40 && (sd_bus.sd_rd | sd_bus.sd_wr) == '0; i++) tick();
      chk({tag, "_grant_seen"}, 64'((sd_bus.sd_rd | sd_bus.sd_wr) != '0), 64'd1);
      oh = onehot(e);
      chk({tag, "_sd_rd"}, 64'(sd_bus.sd_rd), 64'(m_wr[ei] ? '0 : oh));
      chk({tag, "_sd_wr"}, 64'(sd_bus.sd_wr), 64'(m_wr[ei] ? oh : '0));
      chk({tag, "_sd_lba"}, 64'(sd_bus.sd_lba), 64'(m_lba[ei]));
      chk({tag, "_active"}, 64'(active_drv), 64'(ei));
   endtask

   task automatic serve(input string tag, input int delay, input int hold);
      repeat (delay) tick();
      sd_bus.sd_ack = 1'b1;
      tick();
      chk({tag, "_req_drop"}, 64'(sd_bus.sd_rd | sd_bus.sd_wr), 64'd0);
      repeat (hold - 1) tick();
      sd_bus.sd_ack = 1'b0;
      tick();
      chk({tag, "_done_early"}, 64'(done), 64'd0);
      tick();
   endtask

   task automatic expect_done(input string tag, input int e, input logic exp_err);
      int ei;
      ei = (e < 0) ? 0 : e;
      chk({tag, "_done"}, 64'(done), 64'(onehot(e)));
      chk({tag, "_err"}, 64'(err), 64'(exp_err ? onehot(e) : '0));
      chk({tag, "_ready_low"}, 64'(req_ready[ei]), 64'd0);
      m_pend[ei] = 1'b0;
      m_last     = ei;
      tick();
      chk({tag, "_ready_back"}, 64'(req_ready[ei]), 64'd1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int n;
      logic [NDRV-1:0] mask;

      areset        = 1'b1;
      req_valid     = '0;
      req_wr        = '0;
      req_lba       = '0;
      img_mounted   = '0;
      sd_bus.sd_ack = 1'b0;
      model_reset();
      tick();
      tick();
      chk("rst_ready", 64'(req_ready), 64'(3'b111));
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rd", 64'(sd_bus.sd_rd), 64'd0);
      chk("rst_wr", 64'(sd_bus.sd_wr), 64'd0);
      chk("rst_lba", 64'(sd_bus.sd_lba), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_active", 64'(active_drv), 64'd0);
      areset = 1'b0;
      tick();

      // Single read on drive 0, LBA 0x12, ack held four cycles.
      req_lba[0 +: LBA_W] = 32'h12;
      req_valid = 3'b001;
      m_pend[0] = 1'b1;
      m_lba[0]  = 32'h12;
      tick();
      req_valid = '0;
      chk("t1_ready", 64'(req_ready), 64'(3'b110));
      chk("t1_rd_early", 64'(sd_bus.sd_rd), 64'd0);
      tick();
      chk("t1_rd", 64'(sd_bus.sd_rd), 64'(3'b001));
      chk("t1_lba", 64'(sd_bus.sd_lba), 64'h12);
      chk("t1_busy", 64'(busy), 64'd1);
      expect_grant("t1", e);
      serve("t1", 0, 4);
      expect_done("t1", e, 1'b0);

      // All three at once with last=0: grants 1, 2, 0.
      strobe(3'b111, 3'b000);
      for (int j = 0; j < NDRV; j++) begin
         chk("t2_order", 64'(next_grant()), 64'((j + 1) % NDRV));
         expect_grant("t2", e);
         serve("t2", 0, 2);
         expect_done("t2", e, 1'b0);
      end

      // Timeout on drive 1; a strobe into full slot 2 is ignored.
      strobe(3'b110, 3'b000);
      strobe(3'b100, 3'b000);
      expect_grant("t3", e);
      n = 0;
      while ((sd_bus.sd_rd != '0) && (n < 40)) begin
         n++;
         tick();
      end
      chk("t3_issue_len", 64'(n), 64'(TMO));
      tick();
      expect_done("t3", e, 1'b1);
      expect_grant("t3b", e);
      serve("t3b", 1, 2);
      expect_done("t3b", e, 1'b0);

      // Unmount of pending drive 2 while drive 0 is in XFER.
      strobe(3'b001, 3'b000);
      expect_grant("t4", e);
      sd_bus.sd_ack = 1'b1;
      tick();
      strobe(3'b100, 3'b000);
      img_mounted = 3'b100;
      tick();
      img_mounted = '0;
      chk("t4_abort_done", 64'(done), 64'(3'b100));
      chk("t4_abort_err", 64'(err), 64'(3'b100));
      chk("t4_busy", 64'(busy), 64'd1);
      m_pend[2] = 1'b0;
      sd_bus.sd_ack = 1'b0;
      tick();
      tick();
      expect_done("t4", e, 1'b0);
      chk("t4_no_regrant", 64'(sd_bus.sd_rd), 64'd0);
      chk("t4_idle", 64'(busy), 64'd0);

      // Unmount of the active drive: completes with err.
      strobe(3'b010, 3'b000);
      expect_grant("t4m", e);
      img_mounted = 3'b010;
      tick();
      img_mounted = '0;
      serve("t4m", 0, 1);
      expect_done("t4m", e, 1'b1);

      // Reset during XFER.
      strobe(3'b100, 3'b000);
      expect_grant("t5", e);
      sd_bus.sd_ack = 1'b1;
      tick();
      areset = 1'b1;
      tick();
      chk("t5_rd", 64'(sd_bus.sd_rd), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_active", 64'(active_drv), 64'd0);
      chk("t5_lba", 64'(sd_bus.sd_lba), 64'd0);
      chk("t5_ready", 64'(req_ready), 64'(3'b111));
      chk("t5_done", 64'(done), 64'd0);
      areset = 1'b0;
      sd_bus.sd_ack = 1'b0;
      model_reset();
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("t5_no_done", 64'(done), 64'd0);
      end
      strobe(3'b001, 3'b000);
      expect_grant("t5b", e);
      serve("t5b", 0, 1);
      expect_done("t5b", e, 1'b0);

      // Write on drive 1.
`ifdef SD_WRITE_EN
      strobe(3'b010, 3'b010);
      expect_grant("t6", e);
      serve("t6", 0, 2);
      expect_done("t6", e, 1'b0);
`else
      strobe(3'b010, 3'b010);
      chk("t6_done", 64'(done), 64'(3'b010));
      chk("t6_err", 64'(err), 64'(3'b010));
      chk("t6_wr", 64'(sd_bus.sd_wr), 64'd0);
      chk("t6_ready_low", 64'(req_ready), 64'(3'b101));
      tick();
      chk("t6_done_clr", 64'(done), 64'd0);
      chk("t6_ready_back", 64'(req_ready), 64'(3'b111));
      strobe(3'b010, 3'b000);
      expect_grant("t6b", e);
      serve("t6b", 0, 1);
      expect_done("t6b", e, 1'b0);
`endif

      // Randomized rounds of reads with varied ack timing.
      for (int r = 0; r < 25; r++) begin
         mask = 3'($urandom_range(1, 7));
         strobe(mask, 3'b000);
         for (int j = 0; j < NDRV && next_grant() >= 0; j++) begin
            expect_grant("rnd", e);
            serve("rnd", int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            expect_done("rnd", e, 1'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/sd_sector_arbiter.md
# sd_sector_arbiter

Schedules sector read/write requests from the three virtual SD drives (D1, D2, cartridge) onto the single HPS block interface (`sd_lba`, `sd_rd`, `sd_wr`, `sd_ack`). Each drive has a one-deep request slot. The block grants slots round-robin, runs the ack handshake and returns a per-drive completion pulse. It sits between the ZPU-side drive logic and `hps_io`, replacing ad-hoc edge detection on ZPU output bits.

## Interface
Parameters:
- `NDRV`, 3: number of requesters; bit index equals drive index as presented to `hps_io`.
- `LBA_W`, 32: LBA width.
- `TIMEOUT`, 24'd5_000_000: clk_sys cycles to wait for `sd_ack` rising before the request is abandoned.

Ports:
- `clk_sys`  in  1  system clock.
- `areset`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NDRV  one-cycle request strobe per drive.
- `req_wr`  in  NDRV  direction, sampled with `req_valid`: 1 = write, 0 = read.
- `req_lba`  in  NDRV*LBA_W  per-drive LBA, sampled with `req_valid`; drive i occupies bits [i*LBA_W +: LBA_W].
- `req_ready`  out  NDRV  high while the drive's slot is empty.
- `done`  out  NDRV  one-cycle completion pulse.
- `err`  out  NDRV  valid with `done`: 1 = aborted, timed out or unsupported.
- `img_mounted`  in  NDRV  mount event from `hps_io`.
- `sd_lba`  out  LBA_W  LBA of the granted request.
- `sd_rd`, `sd_wr`  out  NDRV  one-hot request to `hps_io`.
- `sd_ack`  in  1  transfer acknowledge from `hps_io`.
- `busy`  out  1  FSM not in IDLE.
- `active_drv`  out  2  index of the granted drive, valid while `busy`.

## Operation
- Slot accept: `req_valid[i] & req_ready[i]` latches `req_wr[i]` and `req_lba[i]` and sets `pend[i]`. `req_ready[i]` drops on the next cycle. A strobe while the slot is full is ignored.
- FSM states: IDLE, ISSUE, XFER, DONE.
  - IDLE: if any `pend` bit is set, the picker chooses the first set bit searching from `(last+1) mod NDRV`. The FSM loads `sd_lba` and `active_drv`, sets the `sd_rd` or `sd_wr` bit for that drive, and moves to ISSUE.
  - ISSUE: the request bit is held until `sd_ack` is sampled high, then both `sd_rd` and `sd_wr` clear and the FSM moves to XFER. If the timeout counter reaches `TIMEOUT-1`, the request clears, `err` is set and the FSM moves to DONE.
  - XFER: waits for `sd_ack` to go low, then moves to DONE.
  - DONE: pulses `done[active]` and `err[active]`, clears `pend[active]`, sets `last = active`, returns to IDLE.
- Mount handling:
  - `img_mounted[i]` on a pending, non-active slot clears it and emits `done[i]` with `err[i]=1` on the next cycle.
  - On the active drive, the transfer completes normally but reports `err=1`.
- Reset values: all outputs 0 except `req_ready = '1`. `pend`, `last` (0) and the counter are cleared. An in-flight `sd_rd`/`sd_wr` drops immediately, with no `done`.

## Timing
- Minimum latency from `req_valid` to `sd_rd`/`sd_wr` high: 2 cycles (accept, then IDLE grant).
- `sd_rd`/`sd_wr` fall the cycle after the first sampled `sd_ack=1`.
- `done` is asserted 2 cycles after `sd_ack` is sampled low (XFER→DONE register, then pulse).
- `req_ready[i]` reasserts the cycle after `done[i]`. A new strobe in that cycle is accepted.
- The timeout counter runs only in ISSUE and clears on entry.
- Simultaneous mount abort and DONE on different drives: both `done` bits pulse in the same cycle.
- Strobes that arrive in IDLE are eligible for grant on the following cycle.

## Configuration
- `SD_WRITE_EN` defined: write requests are arbitrated like reads and drive `sd_wr`.
- `SD_WRITE_EN` undefined: `sd_wr` is tied to 0. An accepted write is never granted; it produces `done[i]` with `err[i]=1` one cycle after acceptance and frees the slot.

## Structure
- Package `sd_arb_pkg` holds:
  - the state enum `sd_arb_state_t` (IDLE, ISSUE, XFER, DONE);
  - `SD_NDRV`;
  - `SD_LBA_W`.
- Sub-module `sd_arb_rr`: combinational round-robin picker. Inputs are `pend` and `last`; outputs are `grant_valid` and `grant_idx`. It is instantiated once.

## Test plan
- Single read, drive 0, LBA 0x12: `sd_lba=0x12` and `sd_rd=3'b001` two cycles after the strobe. Ack held high 4 cycles then low → `sd_rd` clears after the first ack cycle; `done=001`, `err=0`.
- All three drives strobe in the same cycle, `last=0`: grants are in order 1, 2, 0, and each `sd_lba` matches that drive's LBA.
- No ack for `TIMEOUT` (set to 16) cycles: `sd_rd` clears; `done[active]=1` with `err=1`; the next pending drive is granted.
- `img_mounted=3'b100` while drive 2 is pending and drive 0 is in XFER → `done=100`, `err=100` next cycle; drive 0 then completes with `err=0`.
- `areset` during XFER: all outputs return to 0 next cycle, `req_ready=111`, no `done` pulse; a subsequent request is granted to drive 0.
- Write on drive 1: with `SD_WRITE_EN`, `sd_wr=010`; without it, `sd_wr` stays 0 and `done=010`, `err=010` one cycle after acceptance.
